// File: rtl/tdr_echo_capture.sv
// TDR launch/capture: fires a pulse, samples wave_in for WIN cycles, reports arrival, echo delay and class.
// Optional sample buffer with read port when TDR_CAPTURE_DUMP_EN is defined.
module tdr_echo_capture #(
    parameter int PULSE_W = 1,
    parameter int WIN     = 48,
    localparam int IDX_W  = $clog2(WIN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             wave_in,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] arrival,
    output logic [IDX_W-1:0] echo_delay,
    output logic [1:0]       echo_type,
    output logic             timeout
`ifdef TDR_CAPTURE_DUMP_EN
    ,
    input  logic [IDX_W-1:0] dump_addr,
    output logic             dump_data
`endif
);

    // state  | meaning
    // IDLE   | waiting for start
    // LAUNCH | pulse_out high, sampling wave_in
    // LISTEN | pulse done, still sampling wave_in
    // REPORT | one-cycle done strobe, results just updated
    typedef enum logic [1:0] {IDLE, LAUNCH, LISTEN, REPORT} state_t;

    localparam logic [IDX_W-1:0] WIN_L   = IDX_W'(WIN);
    localparam logic [IDX_W-1:0] LAST    = IDX_W'(WIN - 1);
    localparam logic [IDX_W-1:0] PW_L    = IDX_W'(PULSE_W);
    localparam logic [IDX_W-1:0] PW_LAST = IDX_W'(PULSE_W - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] start1;
    logic [IDX_W-1:0] start2;
    logic [IDX_W-1:0] len1;
    logic [1:0]       runs;
    logic             prev_w;
    logic             in_run1;

    logic             run_start;
    logic [1:0]       runs_nx;
    logic [IDX_W-1:0] start1_nx;
    logic [IDX_W-1:0] start2_nx;
    logic [IDX_W-1:0] len1_nx;
    logic             in_run1_nx;

    // Run tracking including the current sample, so the last sample feeds classification directly.
    always_comb begin
        run_start  = wave_in && ((idx == '0) || !prev_w);
        runs_nx    = runs;
        start1_nx  = start1;
        start2_nx  = start2;
        len1_nx    = len1;
        in_run1_nx = in_run1;
        if (run_start) begin
            if (runs != 2'd3) runs_nx = runs + 2'd1;
            if (runs == 2'd0) begin
                start1_nx  = idx;
                len1_nx    = IDX_W'(1);
                in_run1_nx = 1'b1;
            end else if (runs == 2'd1) begin
                start2_nx = idx;
            end
        end else if (in_run1) begin
            if (wave_in) begin
                if (len1 != WIN_L) len1_nx = len1 + IDX_W'(1);
            end else begin
                in_run1_nx = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            start1     <= '0;
            start2     <= '0;
            len1       <= '0;
            runs       <= 2'd0;
            prev_w     <= 1'b0;
            in_run1    <= 1'b0;
            pulse_out  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            arrival    <= '0;
            echo_delay <= '0;
            echo_type  <= 2'b00;
            timeout    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LAUNCH;
                        pulse_out <= 1'b1;
                        busy      <= 1'b1;
                        idx       <= '0;
                        start1    <= '0;
                        start2    <= '0;
                        len1      <= '0;
                        runs      <= 2'd0;
                        prev_w    <= 1'b0;
                        in_run1   <= 1'b0;
                    end
                end
                LAUNCH, LISTEN: begin
                    prev_w  <= wave_in;
                    runs    <= runs_nx;
                    start1  <= start1_nx;
                    start2  <= start2_nx;
                    len1    <= len1_nx;
                    in_run1 <= in_run1_nx;
                    idx     <= idx + IDX_W'(1);
                    if (state == LAUNCH && idx == PW_LAST) begin
                        pulse_out <= 1'b0;
                        state     <= LISTEN;
                    end
                    if (idx == LAST) begin
                        state      <= REPORT;
                        pulse_out  <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        timeout    <= (runs_nx == 2'd0);
                        arrival    <= (runs_nx == 2'd0) ? '0 : start1_nx;
                        echo_delay <= (runs_nx >= 2'd2) ? (start2_nx - start1_nx) : '0;
                        case (runs_nx)
                            2'd0:    echo_type <= 2'b00;
                            2'd1:    echo_type <= (len1_nx > PW_L) ? 2'b10 : 2'b00;
                            2'd2:    echo_type <= 2'b01;
                            default: echo_type <= 2'b11;
                        endcase
                    end
                end
                REPORT:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TDR_CAPTURE_DUMP_EN
    logic [WIN-1:0] cap_buf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_buf <= '0;
        end else if (state == IDLE && start) begin
            cap_buf <= '0;
        end else if (state == LAUNCH || state == LISTEN) begin
            cap_buf[idx] <= wave_in;
        end
    end

    assign dump_data = (dump_addr < WIN_L) ? cap_buf[dump_addr] : 1'b0;
`endif

endmodule
